// File: rtl/spi_led_frame_rx.sv
// Receive side of the APA102-style LED SPI link: oversamples sck/mosi, locks on the
// start frame and decodes each 32-bit LED word into brightness/B/G/R pixel fields.
module spi_led_frame_rx #(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned IDX_W    = 8,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic             CLK,
    input  logic             my_reset_n,
    input  logic             sck,
    input  logic             mosi,
    output logic             pix_valid,
    output logic [IDX_W-1:0] pix_index,
    output logic [4:0]       pix_bright,
    output logic [7:0]       pix_blue,
    output logic [7:0]       pix_green,
    output logic [7:0]       pix_red,
    output logic             frame_done,
    output logic             frame_err,
    output logic             in_frame
);

    localparam int unsigned IDXC_W = IDX_W + 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] HUNT  = 1'b0;
    localparam logic [0:0] FRAME = 1'b1;

    logic [0:0]        state, state_nxt;
    logic              sck_s1, sck_s2, sck_prev;
    logic              mosi_s1, mosi_s2;
    logic [30:0]       sr;
    logic [31:0]       word;
    logic [4:0]        bit_cnt, bit_cnt_nxt;
    logic [5:0]        zrun, zrun_nxt;
    logic [IDXC_W-1:0] idx, idx_nxt, idx_inc;
    logic [IDLE_W-1:0] idle_cnt, idle_nxt;
    logic              rise, timeout_hit, bit_ev;

    logic             pix_valid_nxt, frame_done_nxt, frame_err_nxt;
    logic [IDX_W-1:0] pix_index_nxt;
    logic [4:0]       pix_bright_nxt;
    logic [7:0]       pix_blue_nxt, pix_green_nxt, pix_red_nxt;

    // Edge detect and timeout; a timeout in the same cycle as a rise drops that bit
    always_comb begin
        rise        = sck_s2 & ~sck_prev;
        timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT - 1));
        bit_ev      = rise & ~timeout_hit;
        word        = {sr, mosi_s2};
        idx_inc     = idx + IDXC_W'(1);
        if (rise) begin
            idle_nxt = '0;
        end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
            idle_nxt = idle_cnt + IDLE_W'(1);
        end else begin
            idle_nxt = idle_cnt;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt      = state;
        zrun_nxt       = zrun;
        bit_cnt_nxt    = bit_cnt;
        idx_nxt        = idx;
        pix_valid_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        pix_index_nxt  = pix_index;
        pix_bright_nxt = pix_bright;
        pix_blue_nxt   = pix_blue;
        pix_green_nxt  = pix_green;
        pix_red_nxt    = pix_red;

        case (state)
            HUNT: begin
                if (timeout_hit) begin
                    zrun_nxt = '0;
                end else if (bit_ev) begin
                    if (mosi_s2) begin
                        zrun_nxt = '0;
                    end else if (zrun == 6'd31) begin
                        state_nxt   = FRAME;
                        zrun_nxt    = '0;
                        bit_cnt_nxt = '0;
                        idx_nxt     = '0;
                    end else begin
                        zrun_nxt = zrun + 6'd1;
                    end
                end
            end
            FRAME: begin
                if (timeout_hit) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = HUNT;
                    zrun_nxt      = '0;
                end else if (bit_ev) begin
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        if ((idx < IDXC_W'(NUM_LEDS)) && (word[31:29] == 3'b111)) begin
                            pix_valid_nxt  = 1'b1;
                            pix_index_nxt  = idx[IDX_W-1:0];
                            pix_bright_nxt = word[28:24];
                            pix_blue_nxt   = word[23:16];
                            pix_green_nxt  = word[15:8];
                            pix_red_nxt    = word[7:0];
                            idx_nxt        = idx_inc;
                            if (idx_inc == IDXC_W'(NUM_LEDS)) begin
                                frame_done_nxt = 1'b1;
                                state_nxt      = HUNT;
                            end
                        end else if ((idx == '0) && (word == 32'h0)) begin
                            idx_nxt = '0;
                        end else begin
                            frame_err_nxt = 1'b1;
                            state_nxt     = HUNT;
                            zrun_nxt      = '0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // State, synchronizers, datapath and outputs
    always_ff @(posedge CLK or negedge my_reset_n) begin
        if (!my_reset_n) begin
            state      <= HUNT;
            sck_s1     <= 1'b0;
            sck_s2     <= 1'b0;
            sck_prev   <= 1'b0;
            mosi_s1    <= 1'b0;
            mosi_s2    <= 1'b0;
            sr         <= '0;
            bit_cnt    <= '0;
            zrun       <= '0;
            idx        <= '0;
            idle_cnt   <= '0;
            pix_valid  <= 1'b0;
            pix_index  <= '0;
            pix_bright <= '0;
            pix_blue   <= '0;
            pix_green  <= '0;
            pix_red    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            in_frame   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sck_s1     <= sck;
            sck_s2     <= sck_s1;
            sck_prev   <= sck_s2;
            mosi_s1    <= mosi;
            mosi_s2    <= mosi_s1;
            if (bit_ev) begin
                sr <= word[30:0];
            end
            bit_cnt    <= bit_cnt_nxt;
            zrun       <= zrun_nxt;
            idx        <= idx_nxt;
            idle_cnt   <= idle_nxt;
            pix_valid  <= pix_valid_nxt;
            pix_index  <= pix_index_nxt;
            pix_bright <= pix_bright_nxt;
            pix_blue   <= pix_blue_nxt;
            pix_green  <= pix_green_nxt;
            pix_red    <= pix_red_nxt;
            frame_done <= frame_done_nxt;
            frame_err  <= frame_err_nxt;
            in_frame   <= (state_nxt == FRAME);
        end
    end

endmodule
